// File: rtl/hwpe_stream_split_stride_buf.sv
// Splits one wide stream into NB_OUT_STREAMS narrow streams (contiguous or interleaved per beat), one FIFO per output.
// Latency 1 cycle (no fall-through); input ready depends only on registered FIFO occupancy, never on output readies.
module hwpe_stream_split_stride_buf #(
  parameter int unsigned NB_OUT_STREAMS = 4,
  parameter int unsigned DATA_WIDTH_IN  = 256,
  parameter int unsigned ELEMENT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            clear_i,
  input  logic                                            mode_i,
  input  logic [DATA_WIDTH_IN-1:0]                        push_data_i,
  input  logic [DATA_WIDTH_IN/8-1:0]                      push_strb_i,
  input  logic                                            push_valid_i,
  output logic                                            push_ready_o,
  output logic [DATA_WIDTH_IN-1:0]                        pop_data_o,
  output logic [DATA_WIDTH_IN/8-1:0]                      pop_strb_o,
  output logic [NB_OUT_STREAMS-1:0]                       pop_valid_o,
  input  logic [NB_OUT_STREAMS-1:0]                       pop_ready_i,
  output logic [CNT_WIDTH-1:0]                            beat_cnt_o,
  output logic                                            idle_o
);

  localparam int unsigned N_ELEM         = DATA_WIDTH_IN / ELEMENT_WIDTH;
  localparam int unsigned E              = N_ELEM / NB_OUT_STREAMS;
  localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned EB             = ELEMENT_WIDTH / 8;
  localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;
  localparam int unsigned PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W          = $clog2(FIFO_DEPTH + 1);

  logic                                           ready;
  logic                                           push;
  logic [NB_OUT_STREAMS-1:0]                      full;
  logic [NB_OUT_STREAMS-1:0][DATA_WIDTH_OUT-1:0]  cont_data, intl_data;
  logic [NB_OUT_STREAMS-1:0][STRB_OUT-1:0]        cont_strb, intl_strb;
  logic [CNT_WIDTH-1:0]                           beat_cnt;

  assign ready        = ~rst_i & ~clear_i & ~|full;
  assign push         = push_valid_i & ready;
  assign push_ready_o = ready;
  assign idle_o       = ~|pop_valid_o;
  assign beat_cnt_o   = beat_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      beat_cnt <= '0;
    end else if (push) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_out
    // Both mappings are wired up; mode_i picks one at write time, so buffered beats keep their mapping.
    for (genvar j = 0; j < E; j++) begin : g_slot
      assign cont_data[i][j*ELEMENT_WIDTH +: ELEMENT_WIDTH] = push_data_i[(i*E+j)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      assign intl_data[i][j*ELEMENT_WIDTH +: ELEMENT_WIDTH] = push_data_i[(i+j*NB_OUT_STREAMS)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      assign cont_strb[i][j*EB +: EB] = push_strb_i[(i*E+j)*EB +: EB];
      assign intl_strb[i][j*EB +: EB] = push_strb_i[(i+j*NB_OUT_STREAMS)*EB +: EB];
    end

    logic [DATA_WIDTH_OUT-1:0] mem_data [FIFO_DEPTH];
    logic [STRB_OUT-1:0]       mem_strb [FIFO_DEPTH];
    logic [PTR_W-1:0]          wptr, rptr;
    logic [OCC_W-1:0]          occ;
    logic                      pop;

    assign pop            = pop_valid_o[i] & pop_ready_i[i];
    assign full[i]        = (occ == OCC_W'(FIFO_DEPTH));
    assign pop_valid_o[i] = (occ != '0);
    assign pop_data_o[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = mem_data[rptr];
    assign pop_strb_o[i*STRB_OUT +: STRB_OUT]             = mem_strb[rptr];

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_data[wptr] <= mode_i ? intl_data[i] : cont_data[i];
        mem_strb[wptr] <= mode_i ? intl_strb[i] : cont_strb[i];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        wptr <= '0;
        rptr <= '0;
        occ  <= '0;
      end else begin
        if (push) begin
          wptr <= (wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
        end
        if (pop) begin
          rptr <= (rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
        end
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_split_stride_buf.sv
// Randomized bench for hwpe_stream_split_stride_buf: queue-based reference model plus directed boundary cases.
module tb_hwpe_stream_split_stride_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, clear, mode;
  logic [255:0] push_data;
  logic [31:0]  push_strb;
  logic         push_valid, push_ready;
  logic [255:0] pop_data;
  logic [31:0]  pop_strb;
  logic [3:0]   pop_valid, pop_ready;
  logic [15:0]  beat_cnt;
  logic         idle;

  logic         d1_clear, d1_valid, d1_ready, d1_idle;
  logic [255:0] d1_data, d1_pop_data;
  logic [31:0]  d1_pop_strb;
  logic [3:0]   d1_pop_valid, d1_pop_ready;
  logic [3:0]   d1_cnt;

  hwpe_stream_split_stride_buf dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .push_data_i(push_data), .push_strb_i(push_strb), .push_valid_i(push_valid), .push_ready_o(push_ready),
    .pop_data_o(pop_data), .pop_strb_o(pop_strb), .pop_valid_o(pop_valid), .pop_ready_i(pop_ready),
    .beat_cnt_o(beat_cnt), .idle_o(idle)
  );

  hwpe_stream_split_stride_buf #(.FIFO_DEPTH(1), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(d1_clear), .mode_i(1'b0),
    .push_data_i(d1_data), .push_strb_i(32'hFFFF_FFFF), .push_valid_i(d1_valid), .push_ready_o(d1_ready),
    .pop_data_o(d1_pop_data), .pop_strb_o(d1_pop_strb), .pop_valid_o(d1_pop_valid), .pop_ready_i(d1_pop_ready),
    .beat_cnt_o(d1_cnt), .idle_o(d1_idle)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: output i slot j carries input element i*4+j (contiguous) or i+4*j (interleaved).
  function automatic logic [71:0] ref_slice(input logic [255:0] d, input logic [31:0] s, input logic m, input int i);
    logic [63:0] od;
    logic [7:0]  os;
    int k;
    for (int j = 0; j < 4; j++) begin
      k = m ? (i + 4*j) : (4*i + j);
      od[j*16 +: 16] = d[k*16 +: 16];
      os[j*2 +: 2]   = s[k*2 +: 2];
    end
    return {os, od};
  endfunction

  logic [63:0] qd [4][$];
  logic [7:0]  qs [4][$];
  logic [15:0] mcnt = '0;
  logic        sb_en = 1'b0;
  logic        exp_ready, exp_idle;
  logic [71:0] sl;

  always @(negedge clk) begin
    if (sb_en) begin
      exp_ready = !rst && !clear;
      exp_idle  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (qd[i].size() >= 2) exp_ready = 1'b0;
        if (qd[i].size() != 0) exp_idle = 1'b0;
      end
      chk("push_ready", push_ready, exp_ready);
      chk("idle", idle, exp_idle);
      chk("beat_cnt", beat_cnt, mcnt);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("pop_valid%0d", i), pop_valid[i], qd[i].size() != 0);
        if (qd[i].size() != 0) begin
          chk($sformatf("pop_data%0d", i), pop_data[i*64 +: 64], qd[i][0]);
          chk($sformatf("pop_strb%0d", i), pop_strb[i*8 +: 8], qs[i][0]);
          if (pop_ready[i]) begin
            void'(qd[i].pop_front());
            void'(qs[i].pop_front());
          end
        end
      end
      if (push_valid && push_ready) begin
        for (int i = 0; i < 4; i++) begin
          sl = ref_slice(push_data, push_strb, mode, i);
          qd[i].push_back(sl[63:0]);
          qs[i].push_back(sl[71:64]);
        end
        mcnt = mcnt + 16'd1;
      end
      if (rst || clear) begin
        for (int i = 0; i < 4; i++) begin
          qd[i].delete();
          qs[i].delete();
        end
        mcnt = '0;
      end
    end
  end

  logic alt_mode = 1'b0;

  task automatic new_beat();
    for (int w = 0; w < 8; w++) push_data[w*32 +: 32] = $urandom;
    push_strb = $urandom;
    mode = alt_mode ? ~mode : 1'($urandom_range(1));
  endtask

  // Called just after a rising edge; offers beats until target accepted or budget spent.
  task automatic feed(input int max_cyc, input int target, inout int n, output int used);
    used = 0;
    new_beat();
    push_valid = (n < target);
    while (n < target && used < max_cyc) begin
      @(negedge clk);
      used++;
      if (push_ready) begin
        n++;
        @(posedge clk); #1;
        new_beat();
      end else begin
        @(posedge clk); #1;
      end
      push_valid = (n < target);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && !idle; t++) begin
      @(posedge clk); #1;
    end
    chk("drained_idle", idle, 1'b1);
  endtask

  logic [255:0] dir_data;
  int n, used;

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 1'b0; push_valid = 1'b1;
    push_data = '0; push_strb = '1; pop_ready = 4'hF;
    d1_clear = 1'b0; d1_valid = 1'b0; d1_data = '0; d1_pop_ready = 4'hF;
    @(posedge clk); #1;
    sb_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", push_ready, 1'b0);
      chk("rst_valid", pop_valid, 4'h0);
      chk("rst_cnt", beat_cnt, 16'd0);
      chk("rst_idle", idle, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", push_ready, 1'b1);
    @(posedge clk); #1;

    // Directed: element k holds k, element 5 strobes cleared.
    for (int k = 0; k < 16; k++) dir_data[k*16 +: 16] = 16'(k);
    for (int m = 0; m < 2; m++) begin
      push_data = dir_data; push_strb = 32'hFFFF_F3FF; mode = 1'(m); push_valid = 1'b1;
      @(negedge clk);
      chk("dir_accept", push_ready, 1'b1);
      @(posedge clk); #1;
      push_valid = 1'b0;
      @(negedge clk);
      chk("dir_valid", pop_valid, 4'hF);
      if (m == 0) begin
        chk("cont_out0", pop_data[63:0], 64'h0003_0002_0001_0000);
        chk("cont_out1", pop_data[127:64], 64'h0007_0006_0005_0004);
      end else begin
        chk("intl_out0", pop_data[63:0], 64'h000C_0008_0004_0000);
        chk("intl_out1", pop_data[127:64], 64'h000D_0009_0005_0001);
      end
      chk("dir_strb1", pop_strb[15:8], 8'hF3);
      chk("dir_strb0", pop_strb[7:0], 8'hFF);
      @(posedge clk); #1;
    end

    // Random readiness, mode toggles every beat.
    alt_mode = 1'b1;
    n = 0;
    fork
      feed(2000, 80, n, used);
      for (int t = 0; t < 300; t++) begin
        @(posedge clk); #1;
        pop_ready = 4'($urandom);
      end
    join
    pop_ready = 4'hF;
    chk("rand_beats", n, 80);
    drain();
    alt_mode = 1'b0;

    // Backpressure on output 2 only.
    do_clear();
    pop_ready = 4'b1011;
    n = 0;
    feed(8, 10, n, used);
    chk("bp_accepted", n, 2);
    @(negedge clk);
    chk("bp_ready", push_ready, 1'b0);
    chk("bp_valid", pop_valid, 4'b0100);
    @(posedge clk); #1;
    pop_ready = 4'hF;
    feed(100, 10, n, used);
    chk("bp_total", n, 10);
    drain();
    chk("bp_cnt", beat_cnt, 16'd10);

    // Throughput at depth 2.
    do_clear();
    n = 0;
    feed(1000, 100, n, used);
    chk("tput_d2_cycles", used, 100);
    drain();

    // Clear with two beats buffered and a beat on offer.
    do_clear();
    pop_ready = 4'h0;
    n = 0;
    feed(10, 2, n, used);
    chk("clr_buffered", pop_valid, 4'hF);
    clear = 1'b1; push_valid = 1'b1;
    @(negedge clk);
    chk("clr_ready", push_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    chk("clr_valid", pop_valid, 4'h0);
    chk("clr_idle", idle, 1'b1);
    chk("clr_cnt", beat_cnt, 16'd0);
    @(posedge clk); #1;
    pop_ready = 4'hF;

    // Depth 1: a beat is accepted only every other cycle, so beat 100 lands on cycle 199.
    n = 0; used = 0;
    d1_valid = 1'b1;
    while (n < 100 && used < 1000) begin
      @(negedge clk);
      used++;
      if (d1_ready) n++;
      @(posedge clk); #1;
      for (int w = 0; w < 8; w++) d1_data[w*32 +: 32] = $urandom;
    end
    d1_valid = 1'b0;
    chk("tput_d1_cycles", used, 199);
    @(negedge clk);
    chk("d1_cnt_wrap100", d1_cnt, 4'd4);
    @(posedge clk); #1;
    d1_clear = 1'b1;
    @(posedge clk); #1;
    d1_clear = 1'b0;
    @(negedge clk);
    chk("d1_cnt_clear", d1_cnt, 4'd0);
    @(posedge clk); #1;
    n = 0; used = 0;
    d1_valid = 1'b1;
    while (n < 17 && used < 200) begin
      @(negedge clk);
      used++;
      if (d1_ready) n++;
      @(posedge clk); #1;
    end
    d1_valid = 1'b0;
    @(negedge clk);
    chk("d1_cnt_wrap17", d1_cnt, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
